// File: rtl/neuron_writeback.sv
// Neuron RAM write-back: buffers MAC accumulator results, applies shift/activation/saturation
// to 8 bits and commits them to consecutive neuron RAM addresses for one layer.
module neuron_writeback #(
    parameter int ACC_W      = 16,
    parameter int FRAC_SHIFT = 4,
    parameter int RELU_EN    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       write_base,
    input  logic [7:0]       neuron_count,
    input  logic             acc_valid,
    input  logic [ACC_W-1:0] acc_data,
    output logic             acc_ready,
    output logic             ram_wre,
    output logic [7:0]       ram_write_address,
    output logic [7:0]       ram_write_data,
    output logic             busy,
    output logic             layer_done,
    output logic             sat_flag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic signed [ACC_W-1:0] ZERO_C  = ACC_W'(0);
    localparam logic signed [ACC_W-1:0] U8_MAX  = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] S8_MAX  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] S8_MIN  = -(ACC_W'(128));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Returns {clipped, value}: fixed-point rescale followed by 8-bit activation.
    function automatic logic [8:0] activate(input logic [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        logic [8:0]              res;
        s = $signed(acc) >>> FRAC_SHIFT;
        if (RELU_EN != 0) begin
            if (s < ZERO_C) begin
                res = 9'h000;
            end else if (s > U8_MAX) begin
                res = {1'b1, 8'hFF};
            end else begin
                res = {1'b0, s[7:0]};
            end
        end else begin
            if (s < S8_MIN) begin
                res = {1'b1, 8'h80};
            end else if (s > S8_MAX) begin
                res = {1'b1, 8'h7F};
            end else begin
                res = {1'b0, s[7:0]};
            end
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       base_q, base_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       acc_idx_q, acc_idx_d;
    logic [7:0]       wr_idx_q, wr_idx_d;
    logic             sat_q, sat_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic             wre_q, wre_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;

    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             push_s;
    logic             pop_s;
    logic [8:0]       act_s;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}});
    assign push_s       = (state_q == ST_RUN) && acc_valid && !fifo_full_s;
    assign pop_s        = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !fifo_empty_s;
    assign act_s        = activate(acc_data);

    // Next-state, index, FIFO pointer and write-port logic.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        acc_idx_d = acc_idx_q;
        wr_idx_d  = wr_idx_q;
        sat_d     = sat_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wre_d     = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d    = write_base;
                    count_d   = neuron_count;
                    acc_idx_d = 8'd0;
                    wr_idx_d  = 8'd0;
                    sat_d     = 1'b0;
                    if (neuron_count != 8'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (push_s && ((acc_idx_q + 8'd1) == count_q)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s && (wr_idx_q == count_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (push_s) begin
            acc_idx_d = acc_idx_q + 8'd1;
            wr_ptr_d  = wr_ptr_q + (PTR_W+1)'(1);
            sat_d     = sat_q | act_s[8];
        end else begin
            acc_idx_d = acc_idx_d;
        end

        if (pop_s) begin
            wre_d    = 1'b1;
            addr_d   = base_q + wr_idx_q;
            data_d   = mem_q[rd_ptr_q[PTR_W-1:0]];
            wr_idx_d = wr_idx_q + 8'd1;
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end else begin
            wre_d = 1'b0;
        end
    end

    // State, index, FIFO and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            base_q    <= 8'd0;
            count_q   <= 8'd0;
            acc_idx_q <= 8'd0;
            wr_idx_q  <= 8'd0;
            sat_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wre_q     <= 1'b0;
            addr_q    <= 8'd0;
            data_q    <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            acc_idx_q <= acc_idx_d;
            wr_idx_q  <= wr_idx_d;
            sat_q     <= sat_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wre_q     <= wre_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            if (push_s) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= act_s[7:0];
            end
        end
    end

    assign acc_ready         = (state_q == ST_RUN) && !fifo_full_s;
    assign ram_wre           = wre_q;
    assign ram_write_address = addr_q;
    assign ram_write_data    = data_q;
    assign busy              = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign layer_done        = (state_q == ST_DONE);
    assign sat_flag          = sat_q;

endmodule
